machine_trap_ctrl: RTL

- Trap-entry and MRET sequencer for the machine-mode CSR file. It writes the trap CSRs (mepc, mcause, mtval, mstatus) and the privilege level.
- It takes commit-stage exception flags, pending/enabled interrupts and MRET requests. It selects one event by fixed priority, issues one cycle of CSR write strobes, then redirects fetch through a valid/ready handshake.

---
 rtl/machine_trap_ctrl_if.sv | 9 +
 rtl/machine_trap_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/machine_trap_ctrl_if.sv
// Fetch-redirect handshake between the trap sequencer (master) and fetch (slave).
interface machine_trap_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer: picks one event per commit, writes
// the trap CSRs for one cycle, then redirects fetch through a valid/ready handshake.
module machine_trap_ctrl #(
  parameter bit SUPPORT_U_MODE = 1'b1,
  parameter bit HAS_C          = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        instr_valid_i,
  input  logic [15:0] exc_vec_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] tval_i,
  input  logic        mret_i,
  input  logic [31:0] mip_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        mepc_we_o,
  output logic [31:0] mepc_wdata_o,
  output logic        mcause_we_o,
  output logic [31:0] mcause_wdata_o,
  output logic        mtval_we_o,
  output logic [31:0] mtval_wdata_o,
  output logic        mstatus_we_o,
  output logic [31:0] mstatus_wdata_o,
  output logic [1:0]  priv_o,
  output logic        flush_o,
  output logic        busy_o,
  machine_trap_ctrl_if.master redir
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_TRAP_COMMIT = 2'd1,
    S_MRET_COMMIT = 2'd2,
    S_REDIRECT    = 2'd3
  } state_e;

  localparam logic [1:0] U_MODE   = 2'd0;
  localparam logic [1:0] RES_MODE = 2'd2;
  localparam logic [1:0] M_MODE   = 2'd3;

  localparam int MS_MIE  = 3;
  localparam int MS_MPIE = 7;

  // Index 0 is the highest-priority exception code.
  localparam logic [0:13][3:0] EXC_PRIO = {4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
                                           4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};

  state_e      state_q, state_d;
  logic [1:0]  priv_q;
  logic [1:0]  priv_saved_q;
  logic [4:0]  code_q;
  logic        irq_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic [31:0] redirect_pc_q;

  logic        exc_any;
  logic [4:0]  exc_code;
  logic [31:0] pend;
  logic        irq_any;
  logic [4:0]  irq_code;
  logic        irq_en;
  logic        trap_take;
  logic        mret_take;
  logic [31:0] trap_target;
  logic [31:0] tvec_base;
  logic [1:0]  mret_priv;
  logic [1:0]  mpp_old;
  logic        unused_bits;

  always_comb begin
    exc_any  = 1'b0;
    exc_code = '0;
    for (int i = 13; i >= 0; i--) begin
      if (exc_vec_i[EXC_PRIO[i]]) begin
        exc_any  = 1'b1;
        exc_code = {1'b0, EXC_PRIO[i]};
      end
    end
  end

  assign pend   = mip_i & mie_i;
  assign irq_en = (priv_q != M_MODE) || mstatus_i[MS_MIE];

  always_comb begin
    irq_any  = 1'b0;
    irq_code = '0;
    if (irq_en) begin
      if (pend[11]) begin
        irq_any  = 1'b1;
        irq_code = 5'd11;
      end else if (pend[3]) begin
        irq_any  = 1'b1;
        irq_code = 5'd3;
      end else if (pend[7]) begin
        irq_any  = 1'b1;
        irq_code = 5'd7;
      end
    end
  end

  assign trap_take = (state_q == S_IDLE) && instr_valid_i && (exc_any || irq_any);
  assign mret_take = (state_q == S_IDLE) && instr_valid_i && mret_i && !exc_any && !irq_any;

  // Reserved modes are treated as DIRECT; only mode 01 vectors interrupts.
  assign tvec_base   = {mtvec_i[31:2], 2'b00};
  assign trap_target = (mtvec_i[1:0] == 2'b01 && irq_q) ? tvec_base + {25'd0, code_q, 2'b00}
                                                        : tvec_base;

  assign mpp_old = mstatus_i[12:11];
  always_comb begin
    mret_priv = mpp_old;
    if (mpp_old == RES_MODE || (mpp_old == U_MODE && !SUPPORT_U_MODE)) begin
      mret_priv = M_MODE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trap_take) begin
          state_d = S_TRAP_COMMIT;
        end else if (mret_take) begin
          state_d = S_MRET_COMMIT;
        end
      end
      S_TRAP_COMMIT: state_d = S_REDIRECT;
      S_MRET_COMMIT: state_d = S_REDIRECT;
      S_REDIRECT: begin
        if (redir.redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      priv_q        <= M_MODE;
      priv_saved_q  <= M_MODE;
      code_q        <= '0;
      irq_q         <= 1'b0;
      epc_q         <= '0;
      tval_q        <= '0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trap_take || mret_take) begin
            code_q       <= exc_any ? exc_code : irq_code;
            irq_q        <= !exc_any;
            epc_q        <= epc_i;
            tval_q       <= tval_i;
            priv_saved_q <= priv_q;
          end
        end
        S_TRAP_COMMIT: begin
          priv_q        <= M_MODE;
          redirect_pc_q <= trap_target;
        end
        S_MRET_COMMIT: begin
          priv_q        <= mret_priv;
          redirect_pc_q <= mepc_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mepc_we_o       = 1'b0;
    mepc_wdata_o    = '0;
    mcause_we_o     = 1'b0;
    mcause_wdata_o  = '0;
    mtval_we_o      = 1'b0;
    mtval_wdata_o   = '0;
    mstatus_we_o    = 1'b0;
    mstatus_wdata_o = '0;
    busy_o          = (state_q != S_IDLE);
    flush_o         = (state_q != S_IDLE) || trap_take || mret_take;
    redir.redirect_valid = 1'b0;
    case (state_q)
      S_TRAP_COMMIT: begin
        mepc_we_o       = 1'b1;
        mepc_wdata_o    = HAS_C ? {epc_q[31:1], 1'b0} : {epc_q[31:2], 2'b00};
        mcause_we_o     = 1'b1;
        mcause_wdata_o  = {irq_q, 26'd0, code_q};
        mtval_we_o      = 1'b1;
        mtval_wdata_o   = irq_q ? 32'd0 : tval_q;
        mstatus_we_o    = 1'b1;
        mstatus_wdata_o = mstatus_i;
        mstatus_wdata_o[MS_MPIE] = mstatus_i[MS_MIE];
        mstatus_wdata_o[MS_MIE]  = 1'b0;
        mstatus_wdata_o[12:11]   = priv_saved_q;
      end
      S_MRET_COMMIT: begin
        mstatus_we_o    = 1'b1;
        mstatus_wdata_o = mstatus_i;
        mstatus_wdata_o[MS_MIE]  = mstatus_i[MS_MPIE];
        mstatus_wdata_o[MS_MPIE] = 1'b1;
        mstatus_wdata_o[12:11]   = SUPPORT_U_MODE ? U_MODE : M_MODE;
      end
      S_REDIRECT: redir.redirect_valid = 1'b1;
      default: ;
    endcase
  end

  assign redir.redirect_pc = redirect_pc_q;
  assign priv_o            = priv_q;

  assign unused_bits = ^{pend, epc_q[1:0]};

endmodule
